// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//
// Purpose:
//   Instruction fetch front end. It issues one word-aligned fetch at a time to
//   instruction memory and queues each returned word together with its address
//   in a small FIFO for the decode stage. A redirect (taken branch or jump)
//   flushes the queue and restarts fetching at the new address. An in-flight
//   response that belongs to the old path is discarded in the DROP state.
//
// Parameters:
//   XLEN      address width in bits (32 or 64)
//   DEPTH     instruction queue entries (power of two, 2..16)
//   RESET_PC  first fetch address (word aligned)
//
// Ports:
//   i_clk              clock, all state updates on the rising edge
//   i_rst              asynchronous reset, active low
//   o_imem_req         fetch request valid
//   o_imem_addr        fetch address (word aligned)
//   i_imem_ready       memory accepts the request this cycle
//   i_imem_rvalid      fetch response valid
//   i_imem_rdata       fetched instruction word
//   i_redirect_valid   taken branch/jump: flush and refetch
//   i_redirect_pc      new fetch address (low two bits ignored)
//   i_halt             stop issuing new fetches while high
//   o_ins_valid        queue head valid
//   i_ins_ready        decode consumes the queue head this cycle
//   o_ins_data         queue head instruction (0 when the queue is empty)
//   o_ins_pc           queue head address (0 when the queue is empty)
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_ready,
    input  logic            i_imem_rvalid,
    input  logic [31:0]     i_imem_rdata,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    input  logic            i_halt,
    output logic            o_ins_valid,
    input  logic            i_ins_ready,
    output logic [31:0]     o_ins_data,
    output logic [XLEN-1:0] o_ins_pc
);

    localparam int            PW   = $clog2(DEPTH);
    localparam int            CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DROP
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_reqAddr;
    logic [31:0]     r_qData [DEPTH];
    logic [XLEN-1:0] r_qPc   [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_countNext;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;

    // A redirect withdraws a pending request in the same cycle so the memory
    // never sees a handshake for an address on the abandoned path.
    assign o_imem_req  = (r_state == REQ) && !i_redirect_valid;
    assign o_imem_addr = r_pc;
    assign w_accept    = o_imem_req && i_imem_ready;

    // Redirect has priority: it suppresses both the push of a same-cycle
    // response and any pop requested by decode.
    assign w_push      = (r_state == WAIT) && i_imem_rvalid && !i_redirect_valid;
    assign o_ins_valid = (r_count != '0);
    assign w_pop       = o_ins_valid && i_ins_ready && !i_redirect_valid;

    assign o_ins_data  = o_ins_valid ? r_qData[r_head] : '0;
    assign o_ins_pc    = o_ins_valid ? r_qPc[r_head]   : '0;

    // Queue occupancy after this cycle's push/pop/flush.
    always_comb begin
        w_countNext = r_count;
        if (i_redirect_valid) begin
            w_countNext = '0;
        end else if (w_push && !w_pop) begin
            w_countNext = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_countNext = r_count - CW'(1);
        end
    end

    // Next-state logic. A fetch is only started while a queue slot is free,
    // so every accepted request always has room for its response. When a
    // redirect coincides with the response being waited for (in WAIT or DROP)
    // the stale response is consumed right there and fetching restarts,
    // otherwise DROP would wait for a response that never comes.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (!i_halt && (r_count < FULL)) begin
                    w_nextState = REQ;
                end
            end
            REQ: begin
                if (w_accept) begin
                    w_nextState = WAIT;
                end
            end
            WAIT: begin
                if (i_redirect_valid) begin
                    if (i_imem_rvalid) begin
                        w_nextState = i_halt ? IDLE : REQ;
                    end else begin
                        w_nextState = DROP;
                    end
                end else if (i_imem_rvalid) begin
                    w_nextState = (i_halt || (w_countNext == FULL)) ? IDLE : REQ;
                end
            end
            DROP: begin
                if (i_imem_rvalid) begin
                    w_nextState = i_halt ? IDLE : REQ;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // State, fetch pointer and queue pointers. The address of the accepted
    // request is held in r_reqAddr so it can be queued with its response.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state   <= IDLE;
            r_pc      <= RESET_PC;
            r_reqAddr <= RESET_PC;
            r_count   <= '0;
            r_head    <= '0;
            r_tail    <= '0;
        end else begin
            r_state <= w_nextState;
            r_count <= w_countNext;
            if (i_redirect_valid) begin
                r_pc   <= i_redirect_pc & ~XLEN'(3);
                r_head <= '0;
                r_tail <= '0;
            end else begin
                if (w_accept) begin
                    r_pc      <= r_pc + XLEN'(4);
                    r_reqAddr <= r_pc;
                end
                if (w_push) begin
                    r_tail <= r_tail + PW'(1);
                end
                if (w_pop) begin
                    r_head <= r_head + PW'(1);
                end
            end
        end
    end

    // Queue storage needs no reset: entries are only visible while counted.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_qData[r_tail] <= i_imem_rdata;
            r_qPc[r_tail]   <= r_reqAddr;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit (XLEN=64, RESET_PC at the top of the
// address space so the fetch address wraps to 0). A memory model returns a
// word derived from each accepted address after a configurable latency. The
// expected instruction stream is the program-order address sequence starting
// at the reset or redirect target; a monitor compares every consumed queue
// head against it.
// ----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int              XLEN     = 64;
    localparam int              DEPTH    = 4;
    localparam logic [XLEN-1:0] RESET_PC = 64'hFFFF_FFFF_FFFF_FFFC;

    logic            i_clk;
    logic            i_rst;
    logic            o_imem_req;
    logic [XLEN-1:0] o_imem_addr;
    logic            i_imem_ready;
    logic            i_imem_rvalid;
    logic [31:0]     i_imem_rdata;
    logic            i_redirect_valid;
    logic [XLEN-1:0] i_redirect_pc;
    logic            i_halt;
    logic            o_ins_valid;
    logic            i_ins_ready;
    logic [31:0]     o_ins_data;
    logic [XLEN-1:0] o_ins_pc;

    fetch_unit #(
        .XLEN    (XLEN),
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .o_imem_req      (o_imem_req),
        .o_imem_addr     (o_imem_addr),
        .i_imem_ready    (i_imem_ready),
        .i_imem_rvalid   (i_imem_rvalid),
        .i_imem_rdata    (i_imem_rdata),
        .i_redirect_valid(i_redirect_valid),
        .i_redirect_pc   (i_redirect_pc),
        .i_halt          (i_halt),
        .o_ins_valid     (o_ins_valid),
        .i_ins_ready     (i_ins_ready),
        .o_ins_data      (o_ins_data),
        .o_ins_pc        (o_ins_pc)
    );

    int              nChecks;
    int              nErrors;
    logic [XLEN-1:0] expQ[$];
    int              accCount;
    int              popCount;
    logic [XLEN-1:0] lastAccAddr;
    int              readyPct;
    int              latMin;
    int              latMax;

    // Clock generation.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Contents of instruction memory: a fixed scramble of the address.
    function automatic logic [31:0] memFn(input logic [XLEN-1:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    task automatic checkOutput(input string name, input logic [XLEN-1:0] actual,
                               input logic [XLEN-1:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    // Program order restarts at the given (aligned) address.
    task automatic restartStream(input logic [XLEN-1:0] start);
        expQ.delete();
        for (int i = 0; i < 2048; i++) begin
            expQ.push_back(start + XLEN'(4 * i));
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #2;
        end
    endtask

    task automatic applyStimulus(input int rdyPct, input int lMin, input int lMax,
                                 input logic insRdy);
        readyPct    = rdyPct;
        latMin      = lMin;
        latMax      = lMax;
        i_ins_ready = insRdy;
    endtask

    task automatic applyReset();
        @(posedge i_clk);
        #3;
        i_rst            = 1'b0;
        i_halt           = 1'b0;
        i_redirect_valid = 1'b0;
        repeat (3) @(posedge i_clk);
        restartStream(RESET_PC);
        accCount = 0;
        #3;
        i_rst = 1'b1;
        @(posedge i_clk);
        #2;
        checkBit("first_req", o_imem_req, 1'b1);
        checkOutput("first_addr", o_imem_addr, RESET_PC);
    endtask

    task automatic doRedirect(input logic [XLEN-1:0] target);
        i_redirect_valid = 1'b1;
        i_redirect_pc    = target;
        restartStream(target & ~XLEN'(3));
    endtask

    task automatic waitAcc(input int n, input string name);
        int c;
        c = 0;
        while (accCount < n && c < 200) begin
            tick(1);
            c++;
        end
        nChecks++;
        if (accCount < n) begin
            nErrors++;
            $display("[TB] FAIL %s: timeout, accepted %0d, required %0d", name, accCount, n);
        end
    endtask

    // Memory model: one outstanding request, response after latMin..latMax
    // extra cycles. A request lost to reset is answered with junk right after
    // reset release, which the fetch unit must ignore.
    initial begin
        logic            acc;
        logic [XLEN-1:0] accAddr;
        logic            pending;
        logic            stale;
        logic [XLEN-1:0] pendAddr;
        int              waitCnt;
        pending  = 1'b0;
        stale    = 1'b0;
        pendAddr = '0;
        waitCnt  = 0;
        forever begin
            @(negedge i_clk);
            acc     = o_imem_req && i_imem_ready && i_rst;
            accAddr = o_imem_addr;
            @(posedge i_clk);
            #1;
            i_imem_rvalid = 1'b0;
            i_imem_rdata  = 32'h0;
            if (!i_rst) begin
                stale   = stale | pending;
                pending = 1'b0;
            end else begin
                if (acc) begin
                    pending     = 1'b1;
                    pendAddr    = accAddr;
                    waitCnt     = $urandom_range(latMax, latMin);
                    accCount++;
                    lastAccAddr = accAddr;
                end
                if (stale) begin
                    i_imem_rvalid = 1'b1;
                    i_imem_rdata  = 32'hDEAD_BEEF;
                    stale         = 1'b0;
                end else if (pending) begin
                    if (waitCnt == 0) begin
                        i_imem_rvalid = 1'b1;
                        i_imem_rdata  = memFn(pendAddr);
                        pending       = 1'b0;
                    end else begin
                        waitCnt--;
                    end
                end
            end
            i_imem_ready = ($urandom_range(99, 0) < readyPct);
        end
    end

    // Monitor: request stability, empty-queue outputs and the scoreboard.
    initial begin
        logic            prevStall;
        logic [XLEN-1:0] prevAddr;
        logic [XLEN-1:0] e;
        prevStall = 1'b0;
        prevAddr  = '0;
        forever begin
            @(negedge i_clk);
            if (!i_rst) begin
                prevStall = 1'b0;
            end else begin
                if (prevStall && !i_redirect_valid) begin
                    checkBit("req_hold", o_imem_req, 1'b1);
                    checkOutput("addr_hold", o_imem_addr, prevAddr);
                end
                prevStall = o_imem_req && !i_imem_ready;
                prevAddr  = o_imem_addr;
                if (!o_ins_valid) begin
                    checkOutput("empty_data", XLEN'(o_ins_data), '0);
                    checkOutput("empty_pc", o_ins_pc, '0);
                end else if (i_ins_ready && !i_redirect_valid) begin
                    popCount++;
                    if (expQ.size() == 0) begin
                        nChecks++;
                        nErrors++;
                        $display("[TB] FAIL scoreboard: got pc %h, expected nothing", o_ins_pc);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("ins_pc", o_ins_pc, e);
                        checkOutput("ins_data", XLEN'(o_ins_data), XLEN'(memFn(e)));
                    end
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int p0;
        nChecks          = 0;
        nErrors          = 0;
        accCount         = 0;
        popCount         = 0;
        lastAccAddr      = '0;
        i_rst            = 1'b0;
        i_imem_ready     = 1'b0;
        i_imem_rvalid    = 1'b0;
        i_imem_rdata     = 32'h0;
        i_redirect_valid = 1'b0;
        i_redirect_pc    = '0;
        i_halt           = 1'b0;
        i_ins_ready      = 1'b0;
        applyStimulus(100, 0, 0, 1'b0);

        // Streaming: back-to-back fetches, address wraps after RESET_PC.
        $display("[TB] streaming");
        applyStimulus(100, 0, 0, 1'b1);
        applyReset();
        waitAcc(1, "t1_acc1");
        checkOutput("t1_addr0", lastAccAddr, RESET_PC);
        waitAcc(2, "t1_acc2");
        checkOutput("t1_addr1", lastAccAddr, 64'h0);
        p0 = popCount;
        tick(20);
        checkBit("t1_progress", (popCount - p0) >= 4, 1'b1);

        // Backpressure: queue fills with exactly DEPTH fetches.
        $display("[TB] backpressure");
        applyStimulus(100, 0, 0, 1'b0);
        applyReset();
        tick(30);
        checkOutput("t2_acc", XLEN'(accCount), XLEN'(DEPTH));
        checkBit("t2_req_low", o_imem_req, 1'b0);
        checkBit("t2_valid", o_ins_valid, 1'b1);
        i_ins_ready = 1'b1;
        tick(1);
        i_ins_ready = 1'b0;
        waitAcc(DEPTH + 1, "t2_refetch");
        checkOutput("t2_addr", lastAccAddr, RESET_PC + 64'd16);
        tick(15);
        checkOutput("t2_acc_after", XLEN'(accCount), XLEN'(DEPTH + 1));
        i_ins_ready = 1'b1;
        tick(10);

        // Redirect while waiting: response dropped, refetch at aligned target.
        $display("[TB] redirect in wait");
        applyStimulus(100, 2, 2, 1'b0);
        applyReset();
        waitAcc(1, "t3_acc1");
        doRedirect(64'h103);
        tick(1);
        i_redirect_valid = 1'b0;
        waitAcc(2, "t3_acc2");
        checkOutput("t3_addr", lastAccAddr, 64'h100);
        checkBit("t3_empty", o_ins_valid, 1'b0);
        i_ins_ready = 1'b1;
        tick(15);

        // Redirect together with a response and a pop at count=2.
        $display("[TB] redirect with response");
        applyStimulus(100, 0, 0, 1'b0);
        applyReset();
        waitAcc(3, "t4_acc3");
        checkBit("t4_count2", o_ins_valid, 1'b1);
        doRedirect(64'h2000_0006);
        i_ins_ready = 1'b1;
        tick(1);
        i_redirect_valid = 1'b0;
        i_ins_ready      = 1'b0;
        checkBit("t4_flushed", o_ins_valid, 1'b0);
        waitAcc(4, "t4_acc4");
        checkOutput("t4_addr", lastAccAddr, 64'h2000_0004);
        i_ins_ready = 1'b1;
        tick(10);

        // Halt while waiting: response still queued and drained, no new fetch.
        $display("[TB] halt");
        applyStimulus(100, 2, 2, 1'b1);
        applyReset();
        waitAcc(1, "t5_acc1");
        i_halt = 1'b1;
        p0     = popCount;
        tick(20);
        checkOutput("t5_no_fetch", XLEN'(accCount), 64'd1);
        checkOutput("t5_drained", XLEN'(popCount - p0), 64'd1);
        checkBit("t5_req_low", o_imem_req, 1'b0);
        i_halt = 1'b0;
        waitAcc(2, "t5_acc2");
        checkOutput("t5_addr", lastAccAddr, RESET_PC + 64'd4);

        // Random traffic with redirects and halt windows.
        $display("[TB] random");
        applyStimulus(60, 0, 3, 1'b1);
        applyReset();
        p0 = popCount;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            i_redirect_valid = 1'b0;
            i_ins_ready      = ($urandom_range(3, 0) != 0);
            readyPct         = $urandom_range(90, 30);
            if ($urandom_range(99, 0) < 3) begin
                i_halt = ~i_halt;
            end
            if ($urandom_range(49, 0) == 0) begin
                doRedirect({$urandom(), $urandom()});
            end
            tick(1);
        end
        i_redirect_valid = 1'b0;
        i_halt           = 1'b0;
        i_ins_ready      = 1'b1;
        tick(20);
        checkBit("rand_progress", (popCount - p0) > 100, 1'b1);

        // Reset with a request in flight; stale response must be ignored.
        $display("[TB] reset mid-transaction");
        applyStimulus(100, 5, 5, 1'b1);
        waitAcc(accCount + 1, "t6_acc");
        tick(1);
        applyReset();
        applyStimulus(100, 0, 3, 1'b1);
        p0 = popCount;
        tick(30);
        checkBit("t6_progress", (popCount - p0) >= 4, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
